// File: rtl/sopc_bus_ctrl_pkg.sv
// sopc_bus_ctrl_pkg: FSM encoding, slave indices and default address map shared by the SOPC bus controller
package sopc_bus_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY, RESP} state_t;
  localparam int SLV_ROM = 0;
  localparam int SLV_RAM = 1;
  localparam int SLV_TIMER = 2;
  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE = 32'h4000_0000;
  localparam logic [31:0] TIMER_BASE = 32'h8000_0000;
  localparam logic [31:0] UNMAPPED_BASE = 32'hC000_0000;
  function automatic logic [31:0] slv_base(input int k);
    return k == SLV_ROM ? ROM_BASE : k == SLV_RAM ? RAM_BASE : k == SLV_TIMER ? TIMER_BASE : UNMAPPED_BASE;
  endfunction
endpackage

// File: rtl/sopc_addr_decode.sv
// sopc_addr_decode: maps the slave-index field of an address to a one-hot slave vector plus an unmapped flag
module sopc_addr_decode #(
  parameter int SEL_W = 2,
  parameter int NUM_SLAVES = 3
) (
  input  logic [SEL_W-1:0]      addr_hi,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  unmapped
);
  // one extra bit so NUM_SLAVES == 2**SEL_W does not wrap
  assign unmapped = {1'b0, addr_hi} >= (SEL_W+1)'(NUM_SLAVES);
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_hit
    assign hit[k] = {1'b0, addr_hi} == (SEL_W+1)'(k);
  end
endmodule

// File: rtl/sopc_bus_ctrl.sv
// sopc_bus_ctrl: arbitrates CPU fetch/data ports onto a shared req/ack slave bus.
// Define SOPC_BUS_TIMEOUT_EN to add a watchdog that errors out slaves that never ack.
module sopc_bus_ctrl
  import sopc_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W = 2,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_ce_i,
  input  logic [ADDR_W-1:0]            if_addr_i,
  output logic [DATA_W-1:0]            if_rdata_o,
  output logic                         if_done_o,
  output logic                         if_err_o,
  output logic                         if_stall_o,
  input  logic                         mem_ce_i,
  input  logic                         mem_we_i,
  input  logic [ADDR_W-1:0]            mem_addr_i,
  input  logic [DATA_W/8-1:0]          mem_sel_i,
  input  logic [DATA_W-1:0]            mem_wdata_i,
  output logic [DATA_W-1:0]            mem_rdata_o,
  output logic                         mem_done_o,
  output logic                         mem_err_o,
  output logic                         mem_stall_o,
  output logic [NUM_SLAVES-1:0]        slv_req_o,
  output logic                         slv_we_o,
  output logic [ADDR_W-1:0]            slv_addr_o,
  output logic [DATA_W/8-1:0]          slv_sel_o,
  output logic [DATA_W-1:0]            slv_wdata_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i,
  input  logic [NUM_SLAVES-1:0]        slv_ack_i
);
  state_t state;
  logic [ADDR_W-1:0] req_addr;
  logic [NUM_SLAVES-1:0] hit;
  logic unmapped, ack, expired;
  logic [DATA_W-1:0] rdata, resp_data;
  assign req_addr = mem_ce_i ? mem_addr_i : if_addr_i;
  assign if_stall_o = if_ce_i & ~if_done_o;
  assign mem_stall_o = mem_ce_i & ~mem_done_o;
  assign ack = |(slv_ack_i & slv_req_o);
  sopc_addr_decode #(.SEL_W(SEL_W), .NUM_SLAVES(NUM_SLAVES)) u_dec (
    .addr_hi(req_addr[ADDR_W-1 -: SEL_W]),
    .hit(hit),
    .unmapped(unmapped)
  );
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      if (slv_req_o[k]) rdata = slv_rdata_i[k*DATA_W +: DATA_W];
    resp_data = ack && !slv_we_o ? rdata : '0;
  end
`ifdef SOPC_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else cnt <= state == DBUSY || state == IBUSY ? cnt + 1'b1 : '0;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      slv_req_o <= '0;
      slv_we_o <= 1'b0;
      slv_addr_o <= '0;
      slv_sel_o <= '0;
      slv_wdata_o <= '0;
      if_rdata_o <= '0;
      if_done_o <= 1'b0;
      if_err_o <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o <= 1'b0;
      mem_err_o <= 1'b0;
    end else begin
      if_rdata_o <= '0;
      if_done_o <= 1'b0;
      if_err_o <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o <= 1'b0;
      mem_err_o <= 1'b0;
      case (state)
        IDLE:
          if (mem_ce_i || if_ce_i) begin
            slv_req_o <= hit;
            slv_we_o <= mem_ce_i & mem_we_i;
            slv_addr_o <= req_addr;
            slv_sel_o <= mem_ce_i ? mem_sel_i : '1;
            slv_wdata_o <= mem_ce_i ? mem_wdata_i : '0;
            state <= unmapped ? RESP : mem_ce_i ? DBUSY : IBUSY;
            mem_done_o <= unmapped & mem_ce_i;
            mem_err_o <= unmapped & mem_ce_i;
            if_done_o <= unmapped & ~mem_ce_i;
            if_err_o <= unmapped & ~mem_ce_i;
          end
        DBUSY, IBUSY:
          // a same-cycle ack beats the watchdog
          if (ack || expired) begin
            slv_req_o <= '0;
            state <= RESP;
            if (state == DBUSY) begin
              mem_done_o <= 1'b1;
              mem_err_o <= ~ack;
              mem_rdata_o <= resp_data;
            end else begin
              if_done_o <= 1'b1;
              if_err_o <= ~ack;
              if_rdata_o <= resp_data;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sopc_bus_ctrl.sv
// tb_sopc_bus_ctrl: directed latency cases plus randomized fetch/data traffic checked by a scoreboard
module tb_sopc_bus_ctrl;
  import sopc_bus_ctrl_pkg::*;
  localparam int NS = 3;
  localparam int TO = 8;
  typedef struct {logic [31:0] data; logic err;} exp_t;
  logic clk = 0, rst = 0;
  logic if_ce_i = 0, mem_ce_i = 0, mem_we_i = 0;
  logic [31:0] if_addr_i = 0, mem_addr_i = 0, mem_wdata_i = 0;
  logic [3:0] mem_sel_i = 0;
  logic [31:0] if_rdata_o, mem_rdata_o, slv_addr_o, slv_wdata_o;
  logic if_done_o, if_err_o, if_stall_o, mem_done_o, mem_err_o, mem_stall_o, slv_we_o;
  logic [NS-1:0] slv_req_o, ack, force_ack = 0;
  logic [3:0] slv_sel_o;
  logic [NS*32-1:0] rdata_bus;
  logic [31:0] smem [NS][16];
  logic [31:0] ref_mem [NS][16];
  int checks = 0, failures = 0, cyc = 0;
  int wait_cnt = 0, lat = 0, lat_force = 0;
  bit slave_dead = 0;
  exp_t if_q[$], mem_q[$];
  exp_t fe, me;
  int if_done_cyc, mem_done_cyc, mem_dones = 0, req_rises = 0, req_rise_cyc;
  logic [NS-1:0] prev_req = 0;
  logic [31:0] prev_addr = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sopc_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .SEL_W(2), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .if_err_o(if_err_o), .if_stall_o(if_stall_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .mem_err_o(mem_err_o), .mem_stall_o(mem_stall_o),
    .slv_req_o(slv_req_o), .slv_we_o(slv_we_o), .slv_addr_o(slv_addr_o), .slv_sel_o(slv_sel_o),
    .slv_wdata_o(slv_wdata_o), .slv_rdata_i(rdata_bus), .slv_ack_i(ack)
  );
  function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endfunction
  // slave models: word memories with configurable wait states
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      ack[k] = (slv_req_o[k] && !slave_dead && wait_cnt >= lat) || force_ack[k];
      rdata_bus[k*32 +: 32] = smem[k][slv_addr_o[5:2]];
    end
  end
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++)
      if (slv_req_o[k] && ack[k] && slv_we_o)
        for (int b = 0; b < 4; b++)
          if (slv_sel_o[b]) smem[k][slv_addr_o[5:2]][8*b +: 8] <= slv_wdata_o[8*b +: 8];
    if (|(slv_req_o & ~ack)) wait_cnt <= wait_cnt + 1;
    else begin
      wait_cnt <= 0;
      lat <= lat_force >= 0 ? lat_force : int'($urandom_range(0, 3));
    end
  end
  // monitor / scoreboard
  always @(negedge clk) if (rst) begin
    chk("if_stall", if_stall_o, if_ce_i & ~if_done_o);
    chk("mem_stall", mem_stall_o, mem_ce_i & ~mem_done_o);
    chk("req_onehot", $onehot0(slv_req_o), 1);
    if (slv_req_o != 0 && prev_req == slv_req_o) chk("addr_stable", slv_addr_o, prev_addr);
    if (slv_req_o != 0 && prev_req == 0) begin req_rises++; req_rise_cyc = cyc; end
    prev_req = slv_req_o;
    prev_addr = slv_addr_o;
    if (if_done_o) begin
      if_done_cyc = cyc;
      if (if_q.size() == 0) chk("if_spurious_done", 1, 0);
      else begin
        fe = if_q.pop_front();
        chk("if_rdata", if_rdata_o, fe.data);
        chk("if_err", if_err_o, fe.err);
      end
    end
    if (mem_done_o) begin
      mem_done_cyc = cyc;
      mem_dones++;
      if (mem_q.size() == 0) chk("mem_spurious_done", 1, 0);
      else begin
        me = mem_q.pop_front();
        chk("mem_rdata", mem_rdata_o, me.data);
        chk("mem_err", mem_err_o, me.err);
      end
    end
  end
  task automatic do_if(input logic [31:0] a, output int c0);
    int idx = int'(a[31:30]);
    bit got = 0;
    if_q.push_back('{data: idx >= NS ? 32'h0 : ref_mem[idx][a[5:2]], err: idx >= NS});
    if_ce_i = 1;
    if_addr_i = a;
    c0 = cyc;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = if_done_o; end
    if (!got) chk("if_done_timeout", 0, 1);
    @(posedge clk); #1;
    if_ce_i = 0;
  endtask
  task automatic do_mem(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output int c0);
    int idx = int'(a[31:30]);
    int w = int'(a[5:2]);
    bit got = 0;
    mem_q.push_back('{data: (idx >= NS || we) ? 32'h0 : ref_mem[idx][w], err: idx >= NS});
    if (idx < NS && we)
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][w][8*b +: 8] = d[8*b +: 8];
    mem_ce_i = 1;
    mem_we_i = we;
    mem_addr_i = a;
    mem_sel_i = s;
    mem_wdata_i = d;
    c0 = cyc;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = mem_done_o; end
    if (!got) chk("mem_done_timeout", 0, 1);
    @(posedge clk); #1;
    mem_ce_i = 0;
  endtask
  task automatic gap();
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask
  task automatic rand_if();
    int c;
    logic [31:0] a = slv_base($urandom_range(0, 1) == 1 ? 3 : SLV_ROM) | {26'd0, 4'($urandom), 2'b00};
    do_if(a, c);
  endtask
  task automatic rand_mem();
    int c;
    int idx = int'($urandom_range(0, 3));
    logic we = (idx == SLV_RAM || idx == SLV_TIMER) && $urandom_range(0, 1) == 1;
    logic [31:0] a = slv_base(idx) | {26'd0, 4'($urandom), 2'b00};
    do_mem(we, a, 4'($urandom_range(1, 15)), $urandom, c);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int c0, c1, n;
    for (int k = 0; k < NS; k++)
      for (int w = 0; w < 16; w++) begin
        smem[k][w] = {8'hA0 + 8'(k), 16'h5A5A, 8'(w)};
        ref_mem[k][w] = smem[k][w];
      end
    smem[0][4] = 32'h3401_1100;
    ref_mem[0][4] = 32'h3401_1100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", slv_req_o, 0);
    chk("rst_we", slv_we_o, 0);
    chk("rst_addr", slv_addr_o, 0);
    chk("rst_sel", slv_sel_o, 0);
    chk("rst_wdata", slv_wdata_o, 0);
    chk("rst_if_out", {if_rdata_o, if_done_o, if_err_o}, 0);
    chk("rst_mem_out", {mem_rdata_o, mem_done_o, mem_err_o}, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    // zero-wait ROM fetch
    do_if(32'h0000_0010, c0);
    chk("fetch_latency", if_done_cyc, c0 + 2);
    // simultaneous data write and fetch: data wins
    fork
      do_mem(1, 32'h4000_0004, 4'b0011, 32'hDEAD_BEEF, c0);
      do_if(32'h0000_0010, c1);
    join
    chk("same_issue", c0, c1);
    chk("data_first", mem_done_cyc, c0 + 2);
    chk("fetch_after_data", if_done_cyc, mem_done_cyc + 3);
    do_mem(0, 32'h4000_0004, 4'hF, 0, c0);
    chk("readback_word", ref_mem[SLV_RAM][1], {16'hA15A, 16'hBEEF});
    // wait states
    lat_force = 4;
    do_mem(0, 32'h4000_0008, 4'hF, 0, c0);
    chk("wait_latency", mem_done_cyc, req_rise_cyc + 5);
    lat_force = 0;
    // unmapped
    n = req_rises;
    do_mem(0, 32'hC000_0000, 4'hF, 0, c0);
    chk("unmapped_latency", mem_done_cyc, c0 + 1);
    chk("unmapped_no_req", req_rises, n);
    // reset mid-operation; late ack must not complete anything
    slave_dead = 1;
    mem_ce_i = 1;
    mem_we_i = 0;
    mem_addr_i = 32'h4000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_req", slv_req_o, 3'b010);
    rst = 0;
    mem_ce_i = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("midrst_req", slv_req_o, 0);
    chk("midrst_done", mem_done_o, 0);
    n = mem_dones;
    slave_dead = 0;
    force_ack = '1;
    repeat (3) @(posedge clk);
    #1;
    force_ack = 0;
    chk("late_ack_ignored", mem_dones, n);
`ifdef SOPC_BUS_TIMEOUT_EN
    slave_dead = 1;
    begin
      bit got = 0;
      mem_q.push_back('{data: 32'h0, err: 1'b1});
      mem_ce_i = 1;
      mem_we_i = 0;
      mem_addr_i = 32'h4000_0000;
      c0 = cyc;
      for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = mem_done_o; end
      if (!got) chk("timeout_never_fired", 0, 1);
      chk("timeout_latency", mem_done_cyc, c0 + TO + 1);
      @(posedge clk); #1;
      mem_ce_i = 0;
    end
    slave_dead = 0;
`else
    slave_dead = 1;
    n = mem_dones;
    mem_ce_i = 1;
    mem_we_i = 0;
    mem_addr_i = 32'h4000_0000;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("no_timeout_stall", mem_stall_o, 1);
    chk("no_timeout_done", mem_dones, n);
    rst = 0;
    mem_ce_i = 0;
    @(posedge clk); #1;
    rst = 1;
    slave_dead = 0;
`endif
    // randomized concurrent traffic
    lat_force = -1;
    @(posedge clk); #1;
    fork
      repeat (40) begin rand_if(); gap(); end
      repeat (40) begin rand_mem(); gap(); end
    join
    repeat (4) @(posedge clk);
    chk("if_q_empty", if_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
